// File: rtl/csr_pkg.sv
// csr_pkg: shared constants for the machine-mode CSR file.
//   - 12-bit CSR addresses
//   - mstatus bit positions, write mask and reset value
//   - redirect FSM state encoding
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_0088;
  localparam logic [63:0] MSTATUS_RST   = 64'h0000_0000_0000_1800;

  typedef enum logic { RUN = 1'b0, REDIR = 1'b1 } csr_state_e;

endpackage

// File: rtl/csr_reg_file_if.sv
// csr_reg_file_if: commit/read/trap bus between the core and the CSR file.
//   master: core side (drives addresses, write data, trap/mret/retire)
//   slave : CSR file (drives read data, illegal flag, redirect, mie)
interface csr_reg_file_if #(parameter int XLEN = 64);
  logic [11:0]     csrfin_raddr;
  logic [XLEN-1:0] csrfout_rdata;
  logic            csrfout_illegal;
  logic            csrfin_we;
  logic [11:0]     csrfin_waddr;
  logic [XLEN-1:0] csrfin_wdata;
  logic            csrfin_trap;
  logic [XLEN-1:0] csrfin_trap_pc;
  logic [XLEN-1:0] csrfin_trap_cause;
  logic            csrfin_mret;
  logic            csrfin_retire;
  logic            csrfout_redirect;
  logic [XLEN-1:0] csrfout_redirect_pc;
  logic            csrfout_mie;

  modport master (
    output csrfin_raddr, csrfin_we, csrfin_waddr, csrfin_wdata,
           csrfin_trap, csrfin_trap_pc, csrfin_trap_cause,
           csrfin_mret, csrfin_retire,
    input  csrfout_rdata, csrfout_illegal, csrfout_redirect,
           csrfout_redirect_pc, csrfout_mie
  );

  modport slave (
    input  csrfin_raddr, csrfin_we, csrfin_waddr, csrfin_wdata,
           csrfin_trap, csrfin_trap_pc, csrfin_trap_cause,
           csrfin_mret, csrfin_retire,
    output csrfout_rdata, csrfout_illegal, csrfout_redirect,
           csrfout_redirect_pc, csrfout_mie
  );
endinterface

// File: rtl/csr_counter.sv
// csr_counter: free-running W-bit counter with load.
//   clk, rst  : clock, async active-high reset (count -> 0)
//   inc       : add 1 this cycle (wraps at 2^W-1)
//   load      : take load_data this cycle; overrides inc
//   count     : current value
module csr_counter #(parameter int W = 64) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (load) count <= load_data;
    else if (inc)  count <= count + W'(1);
  end
endmodule

// File: rtl/csr_reg_file.sv
// csr_reg_file: machine-mode CSR storage with trap/mret sequencing.
//   clk, rst : core clock, async active-high reset
//   bus      : csr_reg_file_if.slave (read port, commit write, trap/mret,
//              retire, one-cycle redirect to fetch, mstatus.MIE)
// Optional: define CSR_COUNTERS_EN to add mcycle (0xB00) / minstret (0xB02).
module csr_reg_file
  import csr_pkg::*;
#(parameter int XLEN = 64) (
  input  logic clk,
  input  logic rst,
  csr_reg_file_if.slave bus
);
  csr_state_e      state, state_nxt;
  logic            mie, mpie;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, target;
  logic [XLEN-1:0] mstatus_rd;
  logic            take_trap, take_mret, do_wr;

  // Only MIE/MPIE are stored; MPP reads as machine mode.
  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_rd[MSTATUS_MPIE] = mpie;
    mstatus_rd[MSTATUS_MIE]  = mie;
  end

`ifdef CSR_COUNTERS_EN
  logic [XLEN-1:0] mcycle, minstret;

  csr_counter #(.W(XLEN)) u_mcycle (
    .clk(clk), .rst(rst), .inc(1'b1),
    .load(do_wr && bus.csrfin_waddr == CSR_MCYCLE),
    .load_data(bus.csrfin_wdata), .count(mcycle)
  );
  csr_counter #(.W(XLEN)) u_minstret (
    .clk(clk), .rst(rst), .inc(bus.csrfin_retire),
    .load(do_wr && bus.csrfin_waddr == CSR_MINSTRET),
    .load_data(bus.csrfin_wdata), .count(minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = bus.csrfin_retire;
`endif

  // Read port: purely from register state, no write bypass.
  always_comb begin
    bus.csrfout_rdata   = '0;
    bus.csrfout_illegal = 1'b0;
    case (bus.csrfin_raddr)
      CSR_MSTATUS:  bus.csrfout_rdata = mstatus_rd;
      CSR_MTVEC:    bus.csrfout_rdata = mtvec;
      CSR_MSCRATCH: bus.csrfout_rdata = mscratch;
      CSR_MEPC:     bus.csrfout_rdata = mepc;
      CSR_MCAUSE:   bus.csrfout_rdata = mcause;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:   bus.csrfout_rdata = mcycle;
      CSR_MINSTRET: bus.csrfout_rdata = minstret;
`endif
      default:      bus.csrfout_illegal = 1'b1;
    endcase
  end

  // trap > mret > we, and all of them are ignored while redirecting.
  always_comb begin
    state_nxt = state;
    take_trap = 1'b0;
    take_mret = 1'b0;
    do_wr     = 1'b0;
    case (state)
      RUN: begin
        if (bus.csrfin_trap) begin
          take_trap = 1'b1;
          state_nxt = REDIR;
        end else if (bus.csrfin_mret) begin
          take_mret = 1'b1;
          state_nxt = REDIR;
        end else if (bus.csrfin_we) begin
          do_wr = 1'b1;
        end
      end
      REDIR:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign bus.csrfout_redirect    = (state == REDIR);
  assign bus.csrfout_redirect_pc = (state == REDIR) ? target : '0;
  assign bus.csrfout_mie         = mie;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      mie      <= MSTATUS_RST[MSTATUS_MIE];
      mpie     <= MSTATUS_RST[MSTATUS_MPIE];
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      target   <= '0;
    end else begin
      state <= state_nxt;
      if (take_trap) begin
        mepc   <= bus.csrfin_trap_pc & ~XLEN'(3);
        mcause <= bus.csrfin_trap_cause;
        mpie   <= mie;
        mie    <= 1'b0;
        target <= mtvec;
      end else if (take_mret) begin
        mie    <= mpie;
        mpie   <= 1'b1;
        target <= mepc;
      end else if (do_wr) begin
        case (bus.csrfin_waddr)
          CSR_MSTATUS: begin
            mie  <= bus.csrfin_wdata[MSTATUS_MIE];
            mpie <= bus.csrfin_wdata[MSTATUS_MPIE];
          end
          CSR_MTVEC:    mtvec    <= bus.csrfin_wdata & ~XLEN'(3);
          CSR_MSCRATCH: mscratch <= bus.csrfin_wdata;
          CSR_MEPC:     mepc     <= bus.csrfin_wdata & ~XLEN'(3);
          CSR_MCAUSE:   mcause   <= bus.csrfin_wdata;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_csr_reg_file.sv
// tb_csr_reg_file: directed self-checking bench for csr_reg_file.
// Counter checks are compiled in when CSR_COUNTERS_EN is defined.
module tb_csr_reg_file;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  csr_reg_file_if #(.XLEN(64)) bus ();

  csr_reg_file #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [11:0] a);
    bus.csrfin_raddr = a; #1;
  endtask

  task automatic idle();
    bus.csrfin_we = 1'b0; bus.csrfin_trap = 1'b0; bus.csrfin_mret = 1'b0;
    bus.csrfin_retire = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    bus.csrfin_we = 1'b1; bus.csrfin_waddr = a; bus.csrfin_wdata = d;
    step(); bus.csrfin_we = 1'b0;
  endtask

  task automatic trap(input logic [63:0] pc, input logic [63:0] cause);
    bus.csrfin_trap = 1'b1; bus.csrfin_trap_pc = pc; bus.csrfin_trap_cause = cause;
    step(); bus.csrfin_trap = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] addrs [5];
    logic [63:0] exp   [5];
    addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342};
    exp   = '{64'h1800, 64'h0, 64'h0, 64'h0, 64'h0};
    rst = 1'b1; step(); step();
    checks++; if (bus.csrfout_redirect !== 1'b0) begin errors++; $display("FAIL rst_redirect got %b want 0", bus.csrfout_redirect); end
    checks++; if (bus.csrfout_redirect_pc !== 64'h0) begin errors++; $display("FAIL rst_redirect_pc got %h want 0", bus.csrfout_redirect_pc); end
    checks++; if (bus.csrfout_mie !== 1'b0) begin errors++; $display("FAIL rst_mie got %b want 0", bus.csrfout_mie); end
    rst = 1'b0; step();
    for (int i = 0; i < 5; i++) begin
      rd(addrs[i]);
      checks++; if (bus.csrfout_rdata !== exp[i] || bus.csrfout_illegal !== 1'b0) begin
        errors++; $display("FAIL rst_read[%h] got %h/%b want %h/0", addrs[i], bus.csrfout_rdata, bus.csrfout_illegal, exp[i]);
      end
    end
    rd(12'h7C0);
    checks++; if (bus.csrfout_rdata !== 64'h0 || bus.csrfout_illegal !== 1'b1) begin
      errors++; $display("FAIL unimpl_read got %h/%b want 0/1", bus.csrfout_rdata, bus.csrfout_illegal);
    end
  endtask

  task automatic test_trap();
    // same-cycle read of the written CSR must return the old value
    bus.csrfin_we = 1'b1; bus.csrfin_waddr = 12'h305; bus.csrfin_wdata = 64'h8000_0003;
    rd(12'h305);
    checks++; if (bus.csrfout_rdata !== 64'h0) begin errors++; $display("FAIL no_bypass got %h want 0", bus.csrfout_rdata); end
    step(); bus.csrfin_we = 1'b0;
    rd(12'h305);
    checks++; if (bus.csrfout_rdata !== 64'h8000_0000) begin errors++; $display("FAIL mtvec got %h want 80000000", bus.csrfout_rdata); end
    wr(12'h300, 64'h8);
    checks++; if (bus.csrfout_mie !== 1'b1) begin errors++; $display("FAIL mie_set got %b want 1", bus.csrfout_mie); end
    trap(64'h8000_0104, 64'd11);
    checks++; if (bus.csrfout_redirect !== 1'b1 || bus.csrfout_redirect_pc !== 64'h8000_0000) begin
      errors++; $display("FAIL trap_redirect got %b/%h want 1/80000000", bus.csrfout_redirect, bus.csrfout_redirect_pc);
    end
    rd(12'h341);
    checks++; if (bus.csrfout_rdata !== 64'h8000_0104) begin errors++; $display("FAIL trap_mepc got %h want 80000104", bus.csrfout_rdata); end
    rd(12'h342);
    checks++; if (bus.csrfout_rdata !== 64'd11) begin errors++; $display("FAIL trap_mcause got %h want b", bus.csrfout_rdata); end
    rd(12'h300);
    checks++; if (bus.csrfout_rdata !== 64'h1880 || bus.csrfout_mie !== 1'b0) begin
      errors++; $display("FAIL trap_mstatus got %h/%b want 1880/0", bus.csrfout_rdata, bus.csrfout_mie);
    end
    step();
    checks++; if (bus.csrfout_redirect !== 1'b0 || bus.csrfout_redirect_pc !== 64'h0) begin
      errors++; $display("FAIL trap_redirect_end got %b/%h want 0/0", bus.csrfout_redirect, bus.csrfout_redirect_pc);
    end
  endtask

  task automatic test_mret();
    bus.csrfin_mret = 1'b1; step(); bus.csrfin_mret = 1'b0;
    checks++; if (bus.csrfout_redirect !== 1'b1 || bus.csrfout_redirect_pc !== 64'h8000_0104) begin
      errors++; $display("FAIL mret_redirect got %b/%h want 1/80000104", bus.csrfout_redirect, bus.csrfout_redirect_pc);
    end
    rd(12'h300);
    checks++; if (bus.csrfout_rdata !== 64'h1888 || bus.csrfout_mie !== 1'b1) begin
      errors++; $display("FAIL mret_mstatus got %h/%b want 1888/1", bus.csrfout_rdata, bus.csrfout_mie);
    end
    step();
    checks++; if (bus.csrfout_redirect !== 1'b0) begin errors++; $display("FAIL mret_redirect_end got %b want 0", bus.csrfout_redirect); end
  endtask

  task automatic test_priority();
    bus.csrfin_trap = 1'b1; bus.csrfin_trap_pc = 64'h2000_000A; bus.csrfin_trap_cause = 64'd2;
    bus.csrfin_mret = 1'b1;
    bus.csrfin_we = 1'b1; bus.csrfin_waddr = 12'h340; bus.csrfin_wdata = 64'd5;
    step();
    // now in REDIR: another trap and a write must both be ignored
    bus.csrfin_mret = 1'b0;
    bus.csrfin_trap_pc = 64'h4444; bus.csrfin_trap_cause = 64'd7; bus.csrfin_wdata = 64'd9;
    checks++; if (bus.csrfout_redirect_pc !== 64'h8000_0000) begin errors++; $display("FAIL prio_target got %h want 80000000", bus.csrfout_redirect_pc); end
    rd(12'h341);
    checks++; if (bus.csrfout_rdata !== 64'h2000_0008) begin errors++; $display("FAIL prio_mepc got %h want 20000008", bus.csrfout_rdata); end
    step(); idle();
    rd(12'h340);
    checks++; if (bus.csrfout_rdata !== 64'h0) begin errors++; $display("FAIL prio_mscratch got %h want 0", bus.csrfout_rdata); end
    rd(12'h341);
    checks++; if (bus.csrfout_rdata !== 64'h2000_0008) begin errors++; $display("FAIL redir_trap_mepc got %h want 20000008", bus.csrfout_rdata); end
    rd(12'h342);
    checks++; if (bus.csrfout_rdata !== 64'd2) begin errors++; $display("FAIL redir_trap_mcause got %h want 2", bus.csrfout_rdata); end
    checks++; if (bus.csrfout_redirect !== 1'b0) begin errors++; $display("FAIL redir_trap_redirect got %b want 0", bus.csrfout_redirect); end
  endtask

  task automatic test_back_to_back();
    wr(12'h305, 64'h0000_1000);
    trap(64'h0000_0200, 64'd3);
    step();  // REDIR cycle; trap accepted on the following one
    trap(64'h0000_0300, 64'd8);
    checks++; if (bus.csrfout_redirect !== 1'b1 || bus.csrfout_redirect_pc !== 64'h1000) begin
      errors++; $display("FAIL b2b_redirect got %b/%h want 1/1000", bus.csrfout_redirect, bus.csrfout_redirect_pc);
    end
    rd(12'h341);
    checks++; if (bus.csrfout_rdata !== 64'h300) begin errors++; $display("FAIL b2b_mepc got %h want 300", bus.csrfout_rdata); end
    step();
  endtask

  task automatic test_masks();
    wr(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'h300);
    checks++; if (bus.csrfout_rdata !== 64'h1888) begin errors++; $display("FAIL mstatus_mask got %h want 1888", bus.csrfout_rdata); end
    wr(12'h341, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'h341);
    checks++; if (bus.csrfout_rdata !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL mepc_mask got %h want fffffffffffffffc", bus.csrfout_rdata); end
    wr(12'h340, 64'hDEAD_BEEF_0123_4567);
    rd(12'h340);
    checks++; if (bus.csrfout_rdata !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL mscratch got %h want deadbeef01234567", bus.csrfout_rdata); end
    wr(12'h342, 64'h8000_0000_0000_0007);
    rd(12'h342);
    checks++; if (bus.csrfout_rdata !== 64'h8000_0000_0000_0007) begin errors++; $display("FAIL mcause got %h want 8000000000000007", bus.csrfout_rdata); end
  endtask

  task automatic test_reset_in_redir();
    trap(64'h0000_0500, 64'd1);
    checks++; if (bus.csrfout_redirect !== 1'b1) begin errors++; $display("FAIL rir_pre got %b want 1", bus.csrfout_redirect); end
    #2 rst = 1'b1; #1;
    checks++; if (bus.csrfout_redirect !== 1'b0 || bus.csrfout_redirect_pc !== 64'h0) begin
      errors++; $display("FAIL rir_abort got %b/%h want 0/0", bus.csrfout_redirect, bus.csrfout_redirect_pc);
    end
    step(); rst = 1'b0; step();
    checks++; if (bus.csrfout_redirect !== 1'b0) begin errors++; $display("FAIL rir_after got %b want 0", bus.csrfout_redirect); end
    rd(12'h341);
    checks++; if (bus.csrfout_rdata !== 64'h0) begin errors++; $display("FAIL rir_mepc got %h want 0", bus.csrfout_rdata); end
  endtask

`ifdef CSR_COUNTERS_EN
  task automatic test_counters();
    rd(12'hB02);
    checks++; if (bus.csrfout_rdata !== 64'h0 || bus.csrfout_illegal !== 1'b0) begin
      errors++; $display("FAIL minstret_init got %h/%b want 0/0", bus.csrfout_rdata, bus.csrfout_illegal);
    end
    wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'hB00);
    checks++; if (bus.csrfout_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mcycle_load got %h want ffffffffffffffff", bus.csrfout_rdata); end
    step();
    checks++; if (bus.csrfout_rdata !== 64'h0) begin errors++; $display("FAIL mcycle_wrap got %h want 0", bus.csrfout_rdata); end
    step();
    checks++; if (bus.csrfout_rdata !== 64'h1) begin errors++; $display("FAIL mcycle_inc got %h want 1", bus.csrfout_rdata); end
    bus.csrfin_retire = 1'b1; step(); step(); step(); bus.csrfin_retire = 1'b0;
    rd(12'hB02);
    checks++; if (bus.csrfout_rdata !== 64'd3) begin errors++; $display("FAIL minstret_3 got %h want 3", bus.csrfout_rdata); end
    bus.csrfin_retire = 1'b1; wr(12'hB02, 64'd100); bus.csrfin_retire = 1'b0;
    checks++; if (bus.csrfout_rdata !== 64'd100) begin errors++; $display("FAIL minstret_load_wins got %h want 64", bus.csrfout_rdata); end
  endtask
`else
  task automatic test_counters();
    wr(12'hB00, 64'h55);
    rd(12'hB00);
    checks++; if (bus.csrfout_rdata !== 64'h0 || bus.csrfout_illegal !== 1'b1) begin
      errors++; $display("FAIL mcycle_absent got %h/%b want 0/1", bus.csrfout_rdata, bus.csrfout_illegal);
    end
    rd(12'hB02);
    checks++; if (bus.csrfout_rdata !== 64'h0 || bus.csrfout_illegal !== 1'b1) begin
      errors++; $display("FAIL minstret_absent got %h/%b want 0/1", bus.csrfout_rdata, bus.csrfout_illegal);
    end
  endtask
`endif

  initial begin
    bus.csrfin_raddr = '0; bus.csrfin_waddr = '0; bus.csrfin_wdata = '0;
    bus.csrfin_trap_pc = '0; bus.csrfin_trap_cause = '0;
    idle();
    test_reset();
    test_trap();
    test_mret();
    test_priority();
    test_back_to_back();
    test_masks();
    test_reset_in_redir();
    test_counters();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
